can_tx_frame: RTL and testbench

- Transmit counterpart of the CAN receive shift path.
- Serialises one CAN 2.0A base data frame onto the bus at one bit per baud_clk. The frame content is ID, RTR, IDE, r0, DLC, data bytes, CRC-15, delimiters, ACK slot, EOF and IFS.
- Inserts stuff bits, computes the CRC, performs bitwise arbitration against the sensed bus and checks for acknowledgement.
- Sits between the host frame registers and the bus transceiver; its rx input is the same line that feeds the receive shift register.

---
 rtl/can_tx_frame.sv | 249 ++++++++++++++++++++++++
 tb/tb_can_tx_frame.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/can_tx_frame.sv
// can_tx_frame: serialises one CAN 2.0A base data frame (SOF..IFS), one bit per baud_clk rising edge.
// Latency: SOF is on the bus the cycle after tx_start is sampled in IDLE; busy covers SOF through the last IFS bit.
// Stuffing, CRC-15, arbitration and ACK check are built in. Auto-retry is optional via `define CAN_TX_AUTO_RETRY_EN.
module can_tx_frame #(
  parameter int EOF_BITS  = 7,
  parameter int IFS_BITS  = 3
`ifdef CAN_TX_AUTO_RETRY_EN
  , parameter int MAX_RETRY = 8
`endif
) (
  input  logic        baud_clk,
  input  logic        rst,
  input  logic        tx_start,
  input  logic [10:0] tx_id,
  input  logic [3:0]  tx_dlc,
  input  logic [63:0] tx_data,
  input  logic        rx,
  output logic        tx,
  output logic        busy,
  output logic        done,
  output logic        arb_lost,
  output logic        ack_err
);

  typedef enum logic [3:0] {
    IDLE, SOF, ARB, CTRL, DATA, CRC, CRC_DEL, ACK_SLOT, ACK_DEL, EOF, IFS
`ifdef CAN_TX_AUTO_RETRY_EN
    , WAIT_IDLE
`endif
  } state_t;

  // The cursor (state, cnt) names the field bit on the bus. While stuff_now is set the
  // bus carries a stuff bit and the cursor still points at the field bit before it.
  state_t      state, state_n;
  logic [6:0]  cnt, cnt_n;
  logic        stuff_now, stuff_n;
  logic [2:0]  run_len, run_n;
  logic [14:0] crc, crc_n;
  logic [10:0] id_q;
  logic [3:0]  dlc_q;
  logic [63:0] data_q;
  logic        tx_n, done_n, arb_n, ack_n;
  logic        load, fail, arb_hit, stuff_ins;
  logic [6:0]  data_bits;
`ifdef CAN_TX_AUTO_RETRY_EN
  logic [3:0]  retry_cnt, retry_n;
`endif

  // DLC 9..15 still carries eight bytes.
  assign data_bits = dlc_q[3] ? 7'd64 : {1'b0, dlc_q[2:0], 3'b000};
  assign busy      = (state != IDLE);

  // Next bit selection: arbitration, stuffing, field advance, failure handling.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    crc_n     = crc;
    tx_n      = tx;
    run_n     = run_len;
    done_n    = 1'b0;
    arb_n     = 1'b0;
    ack_n     = 1'b0;
    load      = 1'b0;
    fail      = 1'b0;
`ifdef CAN_TX_AUTO_RETRY_EN
    retry_n   = retry_cnt;
`endif

    // CRC absorbs every unstuffed bit from SOF through the last data bit.
    if (!stuff_now && (state inside {SOF, ARB, CTRL, DATA}))
      crc_n = {crc[13:0], 1'b0} ^ ((crc[14] ^ tx) ? 15'h4599 : 15'h0000);

    arb_hit   = (state == ARB) && !stuff_now && tx && !rx;
    stuff_ins = !arb_hit && (state inside {SOF, ARB, CTRL, DATA, CRC}) && (run_len == 3'd5);
    stuff_n   = stuff_ins;

    if (arb_hit) begin
      arb_n = 1'b1;
      fail  = 1'b1;
    end else if (!stuff_ins) begin
      case (state)
        IDLE: begin
          if (tx_start) begin
            load    = 1'b1;
            state_n = SOF;
            cnt_n   = 7'd0;
            crc_n   = 15'd0;
`ifdef CAN_TX_AUTO_RETRY_EN
            retry_n = 4'd0;
`endif
          end
        end
        SOF: begin
          state_n = ARB;
          cnt_n   = 7'd0;
        end
        ARB: begin
          if (cnt == 7'd11) begin
            state_n = CTRL;
            cnt_n   = 7'd0;
          end else begin
            cnt_n = cnt + 7'd1;
          end
        end
        CTRL: begin
          if (cnt == 7'd5) begin
            state_n = (data_bits == 7'd0) ? CRC : DATA;
            cnt_n   = 7'd0;
          end else begin
            cnt_n = cnt + 7'd1;
          end
        end
        DATA: begin
          if (cnt == data_bits - 7'd1) begin
            state_n = CRC;
            cnt_n   = 7'd0;
          end else begin
            cnt_n = cnt + 7'd1;
          end
        end
        CRC: begin
          if (cnt == 7'd14) begin
            state_n = CRC_DEL;
            cnt_n   = 7'd0;
          end else begin
            cnt_n = cnt + 7'd1;
          end
        end
        CRC_DEL: state_n = ACK_SLOT;
        ACK_SLOT: begin
          if (rx) begin
            ack_n = 1'b1;
            fail  = 1'b1;
          end else begin
            state_n = ACK_DEL;
          end
        end
        ACK_DEL: begin
          state_n = EOF;
          cnt_n   = 7'd0;
        end
        EOF: begin
          if (cnt == 7'(EOF_BITS - 1)) begin
            state_n = IFS;
            cnt_n   = 7'd0;
          end else begin
            cnt_n = cnt + 7'd1;
          end
        end
        IFS: begin
          if (cnt == 7'(IFS_BITS - 1)) begin
            state_n = IDLE;
            cnt_n   = 7'd0;
            done_n  = 1'b1;
          end else begin
            cnt_n = cnt + 7'd1;
          end
        end
`ifdef CAN_TX_AUTO_RETRY_EN
        // Eleven consecutive recessive bits mean the bus is idle again.
        WAIT_IDLE: begin
          if (!rx) begin
            cnt_n = 7'd0;
          end else if (cnt == 7'd10) begin
            state_n = SOF;
            cnt_n   = 7'd0;
            crc_n   = 15'd0;
            retry_n = retry_cnt + 4'd1;
          end else begin
            cnt_n = cnt + 7'd1;
          end
        end
`endif
        default: state_n = IDLE;
      endcase
    end

    if (fail) begin
`ifdef CAN_TX_AUTO_RETRY_EN
      if (retry_cnt == 4'(MAX_RETRY)) begin
        state_n = IDLE;
      end else begin
        state_n = WAIT_IDLE;
      end
`else
      state_n = IDLE;
`endif
      cnt_n   = 7'd0;
    end

    // Bus level of the next bit follows from the next cursor.
    if (stuff_n) begin
      tx_n = ~tx;
    end else begin
      case (state_n)
        SOF:  tx_n = 1'b0;
        ARB:  tx_n = (cnt_n == 7'd11) ? 1'b0 : id_q[4'(4'd10 - cnt_n[3:0])];
        CTRL: tx_n = (cnt_n < 7'd2) ? 1'b0 : dlc_q[2'(3'd5 - cnt_n[2:0])];
        DATA: tx_n = data_q[~cnt_n[5:0]];
        CRC:  tx_n = crc_n[4'(4'd14 - cnt_n[3:0])];
        default: tx_n = 1'b1;
      endcase
    end

    // Run length counts equal bus bits, stuff bits included.
    if (tx_n == tx) run_n = (run_len == 3'd7) ? 3'd7 : run_len + 3'd1;
    else            run_n = 3'd1;
  end

  // State, frame latch and registered bus/pulse outputs.
  always_ff @(posedge baud_clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 7'd0;
      stuff_now <= 1'b0;
      run_len   <= 3'd0;
      crc       <= 15'd0;
      id_q      <= 11'd0;
      dlc_q     <= 4'd0;
      data_q    <= 64'd0;
      tx        <= 1'b1;
      done      <= 1'b0;
      arb_lost  <= 1'b0;
      ack_err   <= 1'b0;
`ifdef CAN_TX_AUTO_RETRY_EN
      retry_cnt <= 4'd0;
`endif
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      stuff_now <= stuff_n;
      run_len   <= run_n;
      crc       <= crc_n;
      tx        <= tx_n;
      done      <= done_n;
      arb_lost  <= arb_n;
      ack_err   <= ack_n;
`ifdef CAN_TX_AUTO_RETRY_EN
      retry_cnt <= retry_n;
`endif
      if (load) begin
        id_q   <= tx_id;
        dlc_q  <= tx_dlc;
        data_q <= tx_data;
      end
    end
  end

endmodule

// File: tb/tb_can_tx_frame.sv
// Bench for can_tx_frame: reference frame built from field rules, polynomial division CRC
// and a queue-based stuffer; captured bus bits are compared and independently destuffed.
`timescale 1ns/1ps
module tb_can_tx_frame;
  logic        baud_clk = 1'b0;
  logic        rst = 1'b1;
  logic        tx_start = 1'b0;
  logic [10:0] tx_id = '0;
  logic [3:0]  tx_dlc = '0;
  logic [63:0] tx_data = '0;
  logic        rx = 1'b1;
  logic        tx, busy, done, arb_lost, ack_err;

  int n_tests = 0;
  int n_fail  = 0;

  bit          exp_q[$];
  bit          cap_q[$];
  bit          ds_q[$];
  logic [14:0] exp_crc;
  int          n_done, n_arb, n_ack, done_idx, ack_idx, arb_idx, end_idx;
  logic        end_tx;

  always #5 baud_clk = ~baud_clk;

`ifdef CAN_TX_AUTO_RETRY_EN
  can_tx_frame #(.MAX_RETRY(2)) dut (
`else
  can_tx_frame dut (
`endif
    .baud_clk(baud_clk), .rst(rst), .tx_start(tx_start), .tx_id(tx_id),
    .tx_dlc(tx_dlc), .tx_data(tx_data), .rx(rx), .tx(tx), .busy(busy),
    .done(done), .arb_lost(arb_lost), .ack_err(ack_err));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  // Expected SOF..CRC bus bits (stuffed) from the frame fields.
  task automatic build_ref(input logic [10:0] id, input logic [3:0] dlc, input logic [63:0] data);
    bit msg[$];
    bit dv[$];
    logic [15:0] gen;
    int nb, run, ms;
    bit last;
    gen = 16'hC599;
    msg.push_back(1'b0);
    for (int i = 10; i >= 0; i--) msg.push_back(id[i]);
    repeat (3) msg.push_back(1'b0);
    for (int i = 3; i >= 0; i--) msg.push_back(dlc[i]);
    nb = (dlc > 4'd8) ? 64 : int'(dlc) * 8;
    for (int i = 0; i < nb; i++) msg.push_back(data[63-i]);
    ms = msg.size();
    dv = msg;
    repeat (15) dv.push_back(1'b0);
    for (int i = 0; i < ms; i++)
      if (dv[i]) for (int j = 0; j < 16; j++) dv[i+j] = dv[i+j] ^ gen[15-j];
    for (int j = 0; j < 15; j++) exp_crc[14-j] = dv[ms+j];
    for (int j = 14; j >= 0; j--) msg.push_back(exp_crc[j]);
    exp_q = {};
    run = 0;
    last = 1'b0;
    foreach (msg[k]) begin
      if (run == 5) begin
        exp_q.push_back(!last);
        last = !last;
        run = 1;
      end
      if (run > 0 && msg[k] == last) run++;
      else run = 1;
      last = msg[k];
      exp_q.push_back(msg[k]);
    end
    if (run == 5) exp_q.push_back(!last);
  endtask

  // Starts a frame and captures bus bits while busy. rx loops tx except at force_idx (driven 0).
  task automatic run_frame(input logic [10:0] id, input logic [3:0] dlc, input logic [63:0] data,
                           input int force_idx, input int rst_at);
    cap_q = {};
    n_done = 0; n_arb = 0; n_ack = 0;
    done_idx = -1; ack_idx = -1; arb_idx = -1; end_idx = -1; end_tx = 1'bx;
    @(negedge baud_clk);
    tx_id = id; tx_dlc = dlc; tx_data = data; tx_start = 1'b1;
    @(posedge baud_clk);
    #1 tx_start = 1'b0;
    for (int idx = 0; idx < 400; idx++) begin
      @(negedge baud_clk);
      if (done)     begin n_done++; done_idx = idx; end
      if (arb_lost) begin n_arb++;  arb_idx  = idx; end
      if (ack_err)  begin n_ack++;  ack_idx  = idx; end
      if (!busy) begin
        end_idx = idx;
        end_tx  = tx;
        break;
      end
      cap_q.push_back(tx);
      rx = (idx == force_idx) ? 1'b0 : tx;
      if (idx == rst_at) begin
        #1 rst = 1'b1;
        #1;
        check("rst_tx_now", tx, 1);
        check("rst_busy_now", busy, 0);
        check("rst_pulses_now", {done, arb_lost, ack_err}, 0);
        end_idx = idx;
        break;
      end
    end
    rx = 1'b1;
    check("frame_ends", end_idx >= 0, 1);
  endtask

  // Recovers fields from the captured bus stream and checks them against the request.
  task automatic check_good(input string tag, input logic [10:0] id, input logic [3:0] dlc, input logic [63:0] data);
    int mism, run, nb, L;
    bit last;
    logic [10:0] g_id;
    logic [3:0]  g_dlc;
    logic [63:0] g_data, w_data;
    logic [14:0] g_crc;
    L = exp_q.size();
    mism = 0;
    for (int i = 0; i < cap_q.size() && i < L + 13; i++)
      if (cap_q[i] !== ((i < L) ? exp_q[i] : 1'b1)) mism++;
    check({tag, "_len"}, cap_q.size(), L + 13);
    check({tag, "_stream"}, mism, 0);
    check({tag, "_done_at"}, done_idx, L + 13);
    check({tag, "_pulses"}, {8'(n_done), 8'(n_ack), 8'(n_arb)}, 24'h010000);
    ds_q = {};
    run = 0;
    last = 1'b0;
    for (int i = 0; i < cap_q.size() - 13; i++) begin
      if (run == 5) begin
        run = 1;
        last = cap_q[i];
        continue;
      end
      if (run > 0 && cap_q[i] == last) run++;
      else run = 1;
      last = cap_q[i];
      ds_q.push_back(cap_q[i]);
    end
    g_id = '0; g_dlc = '0; g_data = '0; w_data = '0; g_crc = '0;
    for (int i = 1; i <= 11; i++) g_id = {g_id[9:0], ds_q[i]};
    for (int i = 15; i <= 18; i++) g_dlc = {g_dlc[2:0], ds_q[i]};
    nb = (dlc > 4'd8) ? 64 : int'(dlc) * 8;
    for (int i = 0; i < nb; i++) begin
      g_data[63-i] = ds_q[19+i];
      w_data[63-i] = data[63-i];
    end
    for (int i = 0; i < 15; i++) g_crc = {g_crc[13:0], ds_q[19+nb+i]};
    check({tag, "_ds_id"}, g_id, id);
    check({tag, "_ds_ctrl"}, {ds_q[0], ds_q[12], ds_q[13], ds_q[14], g_dlc}, {4'b0000, dlc});
    check({tag, "_ds_data"}, g_data, w_data);
    check({tag, "_ds_crc"}, g_crc, exp_crc);
    check({tag, "_ds_len"}, ds_q.size(), 19 + nb + 15);
  endtask

  task automatic good_frame(input string tag, input logic [10:0] id, input logic [3:0] dlc, input logic [63:0] data);
    build_ref(id, dlc, data);
    run_frame(id, dlc, data, exp_q.size() + 1, -1);
    check_good(tag, id, dlc, data);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int maxrun, run, k;
    logic [10:0] rid;
    logic [3:0]  rdlc;
    logic [63:0] rdata;

    // Reset state.
    repeat (3) @(negedge baud_clk);
    check("reset_outputs", {tx, busy, done, arb_lost, ack_err}, 5'b10000);
    rst = 1'b0;
    repeat (2) @(negedge baud_clk);
    check("idle_outputs", {tx, busy, done, arb_lost, ack_err}, 5'b10000);

    // Basic frame.
    good_frame("basic", 11'h123, 4'd1, 64'hA500_0000_0000_0000);

    // Stuffing: all-zero header forces an early stuff bit.
    good_frame("stuff", 11'h000, 4'd0, 64'd0);
    check("stuff_first5_zero", {cap_q[0], cap_q[1], cap_q[2], cap_q[3], cap_q[4]}, 5'b00000);
    check("stuff_bit5", cap_q[5], 1);
    maxrun = 0; run = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0 && cap_q[i] == cap_q[i-1]) run++;
      else run = 1;
      if (run > maxrun) maxrun = run;
    end
    check("stuff_max_run", maxrun, 5);

    // DLC boundary.
    good_frame("dlc15", 11'h555, 4'd15, 64'h0123_4567_89AB_CDEF);

    // Randomised frames.
    for (int t = 0; t < 4; t++) begin
      rid   = 11'($urandom);
      rdlc  = 4'($urandom);
      rdata = {32'($urandom), 32'($urandom)};
      good_frame($sformatf("rand%0d", t), rid, rdlc, rdata);
    end

`ifndef CAN_TX_AUTO_RETRY_EN
    // Arbitration loss on the first ID bit.
    run_frame(11'h7FF, 4'd2, 64'hFFFF_0000_0000_0000, 1, -1);
    check("arb_end_idx", end_idx, 2);
    check("arb_pulse_idx", arb_idx, 2);
    check("arb_tx_after", end_tx, 1);
    check("arb_pulses", {8'(n_done), 8'(n_ack), 8'(n_arb)}, 24'h000001);

    // No acknowledgement.
    build_ref(11'h2A5, 4'd3, 64'h1122_3300_0000_0000);
    run_frame(11'h2A5, 4'd3, 64'h1122_3300_0000_0000, -1, -1);
    check("noack_pulse_idx", ack_idx, exp_q.size() + 2);
    check("noack_end_idx", end_idx, exp_q.size() + 2);
    check("noack_pulses", {8'(n_done), 8'(n_ack), 8'(n_arb)}, 24'h000100);
`else
    // Retry: no ACK on any attempt, MAX_RETRY=2.
    begin
      int pulses[$];
      bit busy_q[$];
      int gap, mism;
      build_ref(11'h2A5, 4'd2, 64'hC3C3_0000_0000_0000);
      cap_q = {};
      @(negedge baud_clk);
      tx_id = 11'h2A5; tx_dlc = 4'd2; tx_data = 64'hC3C3_0000_0000_0000; tx_start = 1'b1;
      @(posedge baud_clk);
      #1 tx_start = 1'b0;
      end_idx = -1;
      n_done = 0;
      for (int idx = 0; idx < 1000; idx++) begin
        @(negedge baud_clk);
        cap_q.push_back(tx);
        busy_q.push_back(busy);
        if (ack_err) pulses.push_back(idx);
        if (done) n_done++;
        rx = tx;
        if (!busy) begin
          end_idx = idx;
          break;
        end
      end
      rx = 1'b1;
      check("retry_ends", end_idx >= 0, 1);
      check("retry_ack_count", pulses.size(), 3);
      check("retry_no_done", n_done, 0);
      if (pulses.size() == 3) begin
        check("retry_busy_kept", {busy_q[pulses[0]], busy_q[pulses[1]], busy_q[pulses[2]]}, 3'b110);
        check("retry_end_at_third", end_idx, pulses[2]);
        for (int p = 0; p < 2; p++) begin
          gap = 0;
          k = pulses[p];
          while (k < cap_q.size() && cap_q[k] == 1'b1) begin
            gap++;
            k++;
          end
          check($sformatf("retry_gap%0d", p), gap, 11);
          mism = 0;
          for (int i = 0; i < exp_q.size(); i++)
            if (cap_q[pulses[p] + 11 + i] !== exp_q[i]) mism++;
          check($sformatf("retry_stream%0d", p), mism, 0);
        end
      end
    end
`endif

    // Reset in the middle of DATA while the bus is dominant.
    build_ref(11'h0F0, 4'd15, 64'h0123_4567_89AB_CDEF);
    k = 25;
    while (k < exp_q.size() && exp_q[k] != 1'b0) k++;
    run_frame(11'h0F0, 4'd15, 64'h0123_4567_89AB_CDEF, -1, k);
    check("rst_was_dominant", cap_q[k], 0);
    run = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge baud_clk);
      if (i == 2) rst = 1'b0;
      if (done || arb_lost || ack_err || busy || !tx) run++;
    end
    check("rst_quiet_after", run, 0);

    // Block is usable again after the abandoned frame.
    good_frame("after_rst", 11'h3C1, 4'd8, 64'hDEAD_BEEF_0BAD_F00D);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
